bram_sp_arbiter: RTL and testbench

- Shares one `bram_sp` instance (single port, synchronous read, 1-cycle latency, 8-lane write strobe) between two requesters, e.g. instruction fetch (r0) and load/store (r1).
- Each requester uses a valid/ready request handshake; read data returns on a registered response strobe.
- Arbitration is round-robin with a bounded burst, so one requester cannot starve the other.

---
 rtl/bram_arb_pkg.sv | 13 +
 rtl/bram_sp.sv | 28 ++
 rtl/rr_grant2.sv | 35 +++
 rtl/bram_sp_arbiter.sv | 108 ++++++++++
 tb/tb_bram_sp_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and widths for the two-requester single-port BRAM arbiter.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_e;

    localparam int STROBE_W = 8;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/bram_sp.sv
// Single-port BRAM: synchronous read (1-cycle latency), 8-lane byte-style write strobe.
module bram_sp #(
    parameter int BRAM_DATA_WIDTH = 80,
    parameter int BRAM_ADDR_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       bram_we_i,
    input  logic [7:0]                 bram_write_strobe_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_i,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_din_i,
    output logic [BRAM_DATA_WIDTH-1:0] bram_dout_o
);

    localparam int LANE_W = BRAM_DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << BRAM_ADDR_WIDTH;

    logic [BRAM_DATA_WIDTH-1:0] mem [DEPTH];

    // Read-first: a read in the same cycle as a write sees the old word.
    always_ff @(posedge clk_i) begin
        bram_dout_o <= mem[bram_addr_i];
        for (int l = 0; l < 8; l++) begin
            if (bram_we_i && bram_write_strobe_i[l])
                mem[bram_addr_i][l*LANE_W +: LANE_W] <= bram_din_i[l*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/rr_grant2.sv
// Combinational 2-way round-robin grant with a bounded burst per owner.
module rr_grant2
    import bram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic [1:0]       valid_i,
    input  owner_e           owner_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             last_i,
    output logic [1:0]       grant_o
);

    logic burst_left;

    assign burst_left = (cnt_i < CNT_W'(MAX_BURST));

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01: grant_o = 2'b01;
            2'b10: grant_o = 2'b10;
            2'b11: begin
                case (owner_i)
                    OWN_R0:  grant_o = burst_left ? 2'b01 : 2'b10;
                    OWN_R1:  grant_o = burst_left ? 2'b10 : 2'b01;
                    // Idle contention goes to whoever was not served last.
                    default: grant_o = last_i ? 2'b01 : 2'b10;
                endcase
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bram_sp_arbiter.sv
// Shares one single-port BRAM between two valid/ready requesters with bounded round-robin.
module bram_sp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = 80,
    parameter int BRAM_ADDR_WIDTH = 8,
    parameter int MAX_BURST       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       r0_valid_i,
    output logic                       r0_ready_o,
    input  logic                       r0_we_i,
    input  logic [STROBE_W-1:0]        r0_strobe_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [BRAM_DATA_WIDTH-1:0] r0_wdata_i,
    output logic                       r0_rvalid_o,
    output logic [BRAM_DATA_WIDTH-1:0] r0_rdata_o,

    input  logic                       r1_valid_i,
    output logic                       r1_ready_o,
    input  logic                       r1_we_i,
    input  logic [STROBE_W-1:0]        r1_strobe_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [BRAM_DATA_WIDTH-1:0] r1_wdata_i,
    output logic                       r1_rvalid_o,
    output logic [BRAM_DATA_WIDTH-1:0] r1_rdata_o,

    output logic                       bram_we_o,
    output logic [STROBE_W-1:0]        bram_write_strobe_o,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din_o,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout_i
);

    owner_e           owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       grant_raw, grant;
    owner_e           grant_owner;

    rr_grant2 #(.MAX_BURST(MAX_BURST)) u_grant (
        .valid_i ({r1_valid_i, r0_valid_i}),
        .owner_i (owner_q),
        .cnt_i   (cnt_q),
        .last_i  (last_q),
        .grant_o (grant_raw)
    );

    // Nothing is accepted while reset is held.
    assign grant      = rst_i ? 2'b00 : grant_raw;
    assign r0_ready_o = grant[0];
    assign r1_ready_o = grant[1];

    always_comb begin
        bram_we_o           = 1'b0;
        bram_write_strobe_o = '0;
        bram_addr_o         = r0_addr_i;
        bram_din_o          = r0_wdata_i;
        if (grant[1]) begin
            bram_we_o           = r1_we_i;
            bram_write_strobe_o = r1_strobe_i;
            bram_addr_o         = r1_addr_i;
            bram_din_o          = r1_wdata_i;
        end else if (grant[0]) begin
            bram_we_o           = r0_we_i;
            bram_write_strobe_o = r0_strobe_i;
        end
    end

    always_comb begin
        owner_d     = OWN_NONE;
        cnt_d       = '0;
        last_d      = last_q;
        grant_owner = grant[1] ? OWN_R1 : OWN_R0;
        rvalid_d    = grant & ~{r1_we_i, r0_we_i};
        if (grant != 2'b00) begin
            owner_d = grant_owner;
            last_d  = grant[1];
            if (owner_q == grant_owner)
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            else
                cnt_d = CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q  <= OWN_NONE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign r0_rvalid_o = rvalid_q[0];
    assign r1_rvalid_o = rvalid_q[1];
    assign r0_rdata_o  = bram_dout_i;
    assign r1_rdata_o  = bram_dout_i;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Directed bench: arbiter (MAX_BURST=4) with a BRAM beside it, plus a MAX_BURST=1 arbiter.
module tb_bram_sp_arbiter;

    localparam int DW = 80;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0;
    logic [7:0]    r0_strobe = 0, r1_strobe = 0;
    logic [AW-1:0] r0_addr = 0, r1_addr = 0;
    logic [DW-1:0] r0_wdata = 0, r1_wdata = 0;
    logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          bram_we;
    logic [7:0]    bram_strobe;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    logic          b_r0_valid = 0, b_r1_valid = 0;
    logic          b_r0_ready, b_r1_ready, b_r0_rvalid, b_r1_rvalid;
    logic [DW-1:0] b_r0_rdata, b_r1_rdata, b_din;
    logic          b_we;
    logic [7:0]    b_strobe;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout = '0;

    int n_cmp = 0;
    int n_fail = 0;

    bram_sp_arbiter #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_we_i(r0_we), .r0_strobe_i(r0_strobe),
        .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_we_i(r1_we), .r1_strobe_i(r1_strobe),
        .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
        .bram_we_o(bram_we), .bram_write_strobe_o(bram_strobe), .bram_addr_o(bram_addr),
        .bram_din_o(bram_din), .bram_dout_i(bram_dout)
    );

    bram_sp #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) u_bram (
        .clk_i(clk), .bram_we_i(bram_we), .bram_write_strobe_i(bram_strobe),
        .bram_addr_i(bram_addr), .bram_din_i(bram_din), .bram_dout_o(bram_dout)
    );

    bram_sp_arbiter #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .MAX_BURST(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(b_r0_valid), .r0_ready_o(b_r0_ready), .r0_we_i(1'b0), .r0_strobe_i(8'h00),
        .r0_addr_i(8'h00), .r0_wdata_i('0), .r0_rvalid_o(b_r0_rvalid), .r0_rdata_o(b_r0_rdata),
        .r1_valid_i(b_r1_valid), .r1_ready_o(b_r1_ready), .r1_we_i(1'b0), .r1_strobe_i(8'h00),
        .r1_addr_i(8'h01), .r1_wdata_i('0), .r1_rvalid_o(b_r1_rvalid), .r1_rdata_o(b_r1_rdata),
        .bram_we_o(b_we), .bram_write_strobe_o(b_strobe), .bram_addr_o(b_addr),
        .bram_din_o(b_din), .bram_dout_i(b_dout)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic we, input logic [7:0] s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        r0_valid = v; r0_we = we; r0_strobe = s; r0_addr = a; r0_wdata = d;
    endtask

    task automatic req1(input logic v, input logic we, input logic [7:0] s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        r1_valid = v; r1_we = we; r1_strobe = s; r1_addr = a; r1_wdata = d;
    endtask

    localparam logic [DW-1:0] D1 = 80'h0123_4567_89AB_CDEF_0011;
    localparam logic [DW-1:0] D5 = 80'hA5A5_0000_FFFF_1234_5678;

    initial begin
        logic exp0, exp1, prev0, prev1, found;

        // Reset: requests are ignored while reset is held.
        req0(1, 1, 8'hFF, 8'h01, D1);
        tick(); tick();
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_r0_rvalid", r0_rvalid, 0);
        chk("rst_r1_rvalid", r1_rvalid, 0);
        rst = 0;

        // Full write then read of 0x01.
        #1;
        chk("wr01_ready", r0_ready, 1);
        chk("wr01_bram_we", bram_we, 1);
        chk("wr01_strobe", bram_strobe, 8'hFF);
        tick();
        req0(1, 0, 8'h00, 8'h01, '0);
        #1;
        chk("rd01_ready", r0_ready, 1);
        chk("rd01_bram_we", bram_we, 0);
        chk("rd01_no_rvalid_after_write", r0_rvalid, 0);
        tick();
        req0(0, 0, 8'h00, 8'h00, '0);
        chk("rd01_rvalid", r0_rvalid, 1);
        chk("rd01_rdata", r0_rdata, D1);
        chk("rd01_r1_rvalid", r1_rvalid, 0);
        #1;
        chk("idle_ready", r0_ready, 0);
        chk("idle_bram_we", bram_we, 0);
        chk("idle_strobe", bram_strobe, 8'h00);
        tick();
        chk("rd01_pulse_end", r0_rvalid, 0);

        // Partial write: only lane 0 (bits 9:0) of 0x10 changes.
        req0(1, 1, 8'hFF, 8'h10, '0);
        tick();
        req0(1, 1, 8'h01, 8'h10, '1);
        tick();
        req0(1, 0, 8'h00, 8'h10, '0);
        tick();
        req0(0, 0, 8'h00, 8'h00, '0);
        chk("part_rvalid", r0_rvalid, 1);
        chk("part_rdata", r0_rdata, 80'h3FF);

        // r1 read of 0x10: exercises r1 path and leaves last=r1.
        req1(1, 0, 8'h00, 8'h10, '0);
        #1;
        chk("r1_rd_ready", r1_ready, 1);
        chk("r1_rd_r0_ready", r0_ready, 0);
        tick();
        req1(0, 0, 8'h00, 8'h00, '0);
        chk("r1_rd_rvalid", r1_rvalid, 1);
        chk("r1_rd_r0_rvalid", r0_rvalid, 0);
        chk("r1_rd_rdata", r1_rdata, 80'h3FF);
        tick();

        // Contention: MAX_BURST=4 gives r0x4,r1x4; MAX_BURST=1 alternates.
        req0(1, 0, 8'h00, 8'h02, '0);
        req1(1, 0, 8'h00, 8'h03, '0);
        b_r0_valid = 1; b_r1_valid = 1;
        prev0 = 0; prev1 = 0;
        for (int i = 0; i < 12; i++) begin
            exp0 = ((i / 4) % 2) == 0;
            exp1 = !exp0;
            #1;
            chk($sformatf("burst4_r0_ready[%0d]", i), r0_ready, exp0);
            chk($sformatf("burst4_r1_ready[%0d]", i), r1_ready, exp1);
            chk($sformatf("burst1_r0_ready[%0d]", i), b_r0_ready, (i % 2) == 0);
            chk($sformatf("burst1_r1_ready[%0d]", i), b_r1_ready, (i % 2) == 1);
            if (i > 0) begin
                chk($sformatf("burst4_r0_rvalid[%0d]", i), r0_rvalid, prev0);
                chk($sformatf("burst4_r1_rvalid[%0d]", i), r1_rvalid, prev1);
            end
            prev0 = exp0; prev1 = exp1;
            tick();
        end
        req0(0, 0, 8'h00, 8'h00, '0);
        req1(0, 0, 8'h00, 8'h00, '0);
        b_r0_valid = 0; b_r1_valid = 0;
        tick();

        // r1 alone for 10 beats: no forced switch.
        req1(1, 0, 8'h00, 8'h04, '0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("r1solo_ready[%0d]", i), r1_ready, 1);
            chk($sformatf("r1solo_r0_ready[%0d]", i), r0_ready, 0);
            tick();
        end
        // r0 arrives while r1 is past its burst budget.
        req0(1, 0, 8'h00, 8'h05, '0);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            #1;
            if (r0_ready) found = 1;
            else tick();
        end
        chk("r0_within_burst", found, 1);
        tick();
        req0(0, 0, 8'h00, 8'h00, '0);
        req1(0, 0, 8'h00, 8'h00, '0);
        tick();

        // Reset half a cycle after an r1 read is accepted drops the response.
        req1(1, 0, 8'h00, 8'h20, '0);
        #1;
        chk("rstmid_accept", r1_ready, 1);
        tick();
        req1(0, 0, 8'h00, 8'h00, '0);
        #3;
        rst = 1;
        #1;
        chk("rstmid_rvalid_dropped", r1_rvalid, 0);
        tick();
        chk("rstmid_rvalid_held", r1_rvalid, 0);
        rst = 0;

        // From reset: r0 write 0x05 and r1 read 0x05 together; r0 wins, r1 sees new data.
        req0(1, 1, 8'hFF, 8'h05, D5);
        req1(1, 0, 8'h00, 8'h05, '0);
        #1;
        chk("raw_r0_first", r0_ready, 1);
        chk("raw_r1_wait", r1_ready, 0);
        chk("raw_bram_we", bram_we, 1);
        chk("raw_bram_addr", bram_addr, 8'h05);
        tick();
        req0(0, 0, 8'h00, 8'h00, '0);
        chk("raw_no_rvalid_after_rst", r1_rvalid, 0);
        #1;
        chk("raw_r1_next", r1_ready, 1);
        tick();
        req1(0, 0, 8'h00, 8'h00, '0);
        chk("raw_r1_rvalid", r1_rvalid, 1);
        chk("raw_r0_rvalid", r0_rvalid, 0);
        chk("raw_r1_rdata", r1_rdata, D5);
        tick();
        chk("raw_pulse_end", r1_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
